// File: rtl/adder_operand_loader.sv
// Byte-serial operand loader for the 32-bit adder: assembles operand a then operand b
// (LSB first) and presents the pair under a valid/ready handshake.
module adder_operand_loader #(
  parameter int unsigned OP_W   = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              frame_err,
  output logic [CNT_W-1:0]  pair_cnt
);

  localparam int unsigned NumBytes = OP_W / BYTE_W;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StPresent
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   byte_cnt_q;
  logic [OP_W-1:0]   op_a_q;
  logic [OP_W-1:0]   op_b_q;
  logic              op_valid_q;
  logic              in_ready_q;
  logic              frame_err_q;
  logic [CNT_W-1:0]  pair_cnt_q;

  logic accept;
  logic last_byte;

  assign accept    = in_valid && in_ready_q;
  assign last_byte = (byte_cnt_q == LastIdx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StLoadA;
      byte_cnt_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StLoadA: begin
          // Ready rises on the first cycle after reset release.
          in_ready_q <= 1'b1;
          if (accept) begin
            for (int k = 0; k < int'(NumBytes); k++) begin
              if (byte_cnt_q == IdxW'(k)) op_a_q[k*BYTE_W +: BYTE_W] <= in_data;
            end
            if (in_last) begin
              frame_err_q <= 1'b1;
              byte_cnt_q  <= '0;
            end else if (last_byte) begin
              state_q    <= StLoadB;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (accept) begin
            for (int k = 0; k < int'(NumBytes); k++) begin
              if (byte_cnt_q == IdxW'(k)) op_b_q[k*BYTE_W +: BYTE_W] <= in_data;
            end
            if (last_byte && in_last) begin
              state_q    <= StPresent;
              byte_cnt_q <= '0;
              op_valid_q <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (last_byte || in_last) begin
              // Short or long frame: drop it and resynchronise on the next frame.
              state_q     <= StLoadA;
              byte_cnt_q  <= '0;
              frame_err_q <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StPresent: begin
          if (op_valid_q && op_ready) begin
            op_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            pair_cnt_q <= pair_cnt_q + 1'b1;
            state_q    <= StLoadA;
          end
        end
        default: begin
          state_q    <= StLoadA;
          byte_cnt_q <= '0;
          op_valid_q <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign frame_err = frame_err_q;
  assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader; a scoreboard queue holds expected {a, b} pairs
// that a monitor pops and compares at each output handshake.
module tb_adder_operand_loader;

  localparam int unsigned OpW   = 32;
  localparam int unsigned ByteW = 8;
  // Narrow counter so the wrap case needs only 2^CntW+1 frames.
  localparam int unsigned CntW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [ByteW-1:0] in_data;
  logic             in_last;
  logic [OpW-1:0]   op_a;
  logic [OpW-1:0]   op_b;
  logic             op_valid;
  logic             op_ready;
  logic             frame_err;
  logic [CntW-1:0]  pair_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  int          cyc = 0;
  int          last_hs = -1;
  bit          period_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adder_operand_loader #(
    .OP_W  (OpW),
    .BYTE_W(ByteW),
    .CNT_W (CntW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .frame_err(frame_err),
    .pair_cnt (pair_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: values seen just after the falling edge are those present at the next rising edge.
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (rst_n === 1'b1 && op_valid === 1'b1 && op_ready === 1'b1) begin
      check("pair_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("op_a", 64'(op_a), 64'(e[63:32]));
        check("op_b", 64'(op_b), 64'(e[31:0]));
        if (period_chk && last_hs >= 0) check("pair_period", 64'(cyc - last_hs), 64'd9);
        last_hs = cyc;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int last_at,
                            input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (i < 4) send_byte(a[i*8 +: 8], i == last_at);
      else       send_byte(b[(i-4)*8 +: 8], i == last_at);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_op_valid"}, 64'(op_valid), 64'd0);
    check({tag, "_op_a"}, 64'(op_a), 64'd0);
    check({tag, "_op_b"}, 64'(op_b), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_pair_cnt"}, 64'(pair_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    op_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(in_ready), 64'd1);

    // Basic frame, op_ready held high
    exp_q.push_back({32'h12345678, 32'h01020304});
    send_frame(32'h12345678, 32'h01020304, 7, 8);
    in_valid = 1'b0;
    check("t1_valid_latency", 64'(op_valid), 64'd1);
    check("t1_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t1_pair_cnt", 64'(pair_cnt), 64'd1);
    check("t1_in_ready_back", 64'(in_ready), 64'd1);
    check("t1_valid_drop", 64'(op_valid), 64'd0);

    // Backpressure for 5 cycles
    op_ready = 1'b0;
    exp_q.push_back({32'h12345678, 32'h01020304});
    send_frame(32'h12345678, 32'h01020304, 7, 8);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(op_valid), 64'd1);
      check("hold_a", 64'(op_a), 64'h12345678);
      check("hold_b", 64'(op_b), 64'h01020304);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    op_ready = 1'b1;
    @(negedge clk);
    check("hold_in_ready_after", 64'(in_ready), 64'd1);
    check("hold_pair_cnt", 64'(pair_cnt), 64'd2);

    // in_last on 3rd byte
    send_frame(32'hdeadbeef, 32'h0, 2, 3);
    in_valid = 1'b0;
    check("early_last_err", 64'(frame_err), 64'd1);
    @(negedge clk);
    check("early_last_err_pulse", 64'(frame_err), 64'd0);
    check("early_last_cnt", 64'(pair_cnt), 64'd2);
    exp_q.push_back({32'hffffffff, 32'h00000001});
    send_frame(32'hffffffff, 32'h00000001, 7, 8);
    in_valid = 1'b0;
    drain();
    check("after_early_cnt", 64'(pair_cnt), 64'd3);

    // 8th byte without in_last
    send_frame(32'h55aa55aa, 32'haa55aa55, -1, 8);
    in_valid = 1'b0;
    check("no_last_err", 64'(frame_err), 64'd1);
    check("no_last_valid", 64'(op_valid), 64'd0);
    @(negedge clk);
    check("no_last_valid2", 64'(op_valid), 64'd0);
    check("no_last_cnt", 64'(pair_cnt), 64'd3);
    exp_q.push_back({32'haabbccdd, 32'h11223344});
    send_frame(32'haabbccdd, 32'h11223344, 7, 8);
    in_valid = 1'b0;
    drain();
    check("after_no_last_cnt", 64'(pair_cnt), 64'd4);

    // Reset after 5th byte
    send_frame(32'h11111111, 32'h22222222, -1, 5);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({32'hcafef00d, 32'h0badc0de});
    send_frame(32'hcafef00d, 32'h0badc0de, 7, 8);
    in_valid = 1'b0;
    drain();
    check("after_reset_cnt", 64'(pair_cnt), 64'd1);

    // Reset while a pair is pending
    op_ready = 1'b0;
    send_frame(32'h0f0f0f0f, 32'hf0f0f0f0, 7, 8);
    in_valid = 1'b0;
    check("pending_valid", 64'(op_valid), 64'd1);
    rst_n = 1'b0;
    op_ready = 1'b1;
    @(negedge clk);
    check("pending_dropped", 64'(op_valid), 64'd0);
    check("pending_cnt", 64'(pair_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back frames through the counter wrap, 9-cycle period
    period_chk = 1'b1;
    last_hs = -1;
    for (int f = 0; f < (1 << CntW) + 1; f++) begin
      ra = $urandom;
      rb = $urandom;
      exp_q.push_back({ra, rb});
      send_frame(ra, rb, 7, 8);
    end
    in_valid = 1'b0;
    drain();
    period_chk = 1'b0;
    check("wrap_cnt", 64'(pair_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
